// File: rtl/sprite_anim_pkg.sv
// Shared types and per-animation frame counts
// for the sprite animation controller.
package sprite_anim_pkg;

    typedef enum logic [1:0] {
        ANIM_IDLE   = 2'd0,
        ANIM_RUN    = 2'd1,
        ANIM_JUMP   = 2'd2,
        ANIM_ATTACK = 2'd3
    } anim_t;

    localparam logic [2:0] IDLE_FRAMES   = 3'd2;
    localparam logic [2:0] RUN_FRAMES    = 3'd6;
    localparam logic [2:0] JUMP_FRAMES   = 3'd4;
    localparam logic [2:0] ATTACK_FRAMES = 3'd5;

    function automatic logic [2:0] frame_count(
        input anim_t a
    );
        logic [2:0] n;
        unique case (a)
            ANIM_IDLE:   n = IDLE_FRAMES;
            ANIM_RUN:    n = RUN_FRAMES;
            ANIM_JUMP:   n = JUMP_FRAMES;
            ANIM_ATTACK: n = ATTACK_FRAMES;
            default:     n = IDLE_FRAMES;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl_counter.sv
// Hold-tick counter and frame index with wrap,
// clear on animation change and a terminal flag.
module anim_frame_counter
    import sprite_anim_pkg::*;
#(
    parameter int HOLD_TICKS = 4
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       clear,
    input  logic [2:0] frame_count,
    output logic [2:0] frame_idx,
    output logic       terminal
);

    localparam logic [3:0] HOLD_LAST =
        4'(HOLD_TICKS - 1);

    logic [3:0] hold;
    logic       hold_last;
    logic       frame_last;

    assign hold_last  = (hold == HOLD_LAST);
    assign frame_last =
        (frame_idx == frame_count - 3'd1);
    assign terminal   = hold_last && frame_last;

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hold      <= '0;
            frame_idx <= '0;
        end else if (tick) begin
            if (clear) begin
                hold      <= '0;
                frame_idx <= '0;
            end else if (hold_last) begin
                hold      <= '0;
                frame_idx <= frame_last ? 3'd0
                                        : frame_idx + 3'd1;
            end else begin
                hold <= hold + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation FSM: looping idle/run and
// non-interruptible one-shot jump/attack.
module sprite_anim_ctrl
    import sprite_anim_pkg::*;
#(
    parameter int HOLD_TICKS = 4
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       run,
    input  logic       jump_req,
    input  logic       attack_req,
    input  logic       facing_left,
    output logic [1:0] anim_id,
    output logic [2:0] frame_idx,
    output logic       flip_x,
    output logic       busy,
    output logic       anim_done
);

    localparam logic [1:0] ST_IDLE   = ANIM_IDLE;
    localparam logic [1:0] ST_RUN    = ANIM_RUN;
    localparam logic [1:0] ST_JUMP   = ANIM_JUMP;
    localparam logic [1:0] ST_ATTACK = ANIM_ATTACK;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       pend_atk;
    logic       pend_jmp;
    logic       atk_now;
    logic       jmp_now;
    logic       one_shot;
    logic       terminal;
    logic       clear;
    logic       done_next;
    logic       next_busy;

    assign one_shot = (state == ST_JUMP) ||
                      (state == ST_ATTACK);
    assign atk_now  = pend_atk | attack_req;
    assign jmp_now  = pend_jmp | jump_req;
    assign anim_id  = state;
    assign clear    = (next_state != state);
    assign next_busy = (next_state == ST_JUMP) ||
                       (next_state == ST_ATTACK);

    // Attack outranks jump when both are pending.
    always_comb begin
        next_state = state;
        done_next  = 1'b0;
        if (one_shot) begin
            if (terminal) begin
                next_state = run ? ST_RUN : ST_IDLE;
                done_next  = 1'b1;
            end
        end else if (atk_now) begin
            next_state = ST_ATTACK;
        end else if (jmp_now) begin
            next_state = ST_JUMP;
        end else if (run) begin
            next_state = ST_RUN;
        end else begin
            next_state = ST_IDLE;
        end
    end

    anim_frame_counter #(
        .HOLD_TICKS (HOLD_TICKS)
    ) u_counter (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .tick        (frame_tick),
        .clear       (clear),
        .frame_count (frame_count(anim_t'(state))),
        .frame_idx   (frame_idx),
        .terminal    (terminal)
    );

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            flip_x    <= 1'b0;
            busy      <= 1'b0;
            anim_done <= 1'b0;
            pend_atk  <= 1'b0;
            pend_jmp  <= 1'b0;
        end else begin
            anim_done <= frame_tick & done_next;
            // Requests seen while busy are dropped.
            if (one_shot || frame_tick) begin
                pend_atk <= 1'b0;
                pend_jmp <= 1'b0;
            end else begin
                pend_atk <= atk_now;
                pend_jmp <= jmp_now;
            end
            if (frame_tick) begin
                state <= next_state;
                busy  <= next_busy;
                if (!one_shot) begin
                    flip_x <= facing_left;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Scoreboard bench for sprite_anim_ctrl with a
// tick-elapsed reference model and random stimulus.
module tb_sprite_anim_ctrl;

    localparam int H = 4;

    logic       vga_clk;
    logic       reset;
    logic       frame_tick;
    logic       run;
    logic       jump_req;
    logic       attack_req;
    logic       facing_left;
    logic [1:0] anim_id;
    logic [2:0] frame_idx;
    logic       flip_x;
    logic       busy;
    logic       anim_done;

    sprite_anim_ctrl #(
        .HOLD_TICKS (H)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .run         (run),
        .jump_req    (jump_req),
        .attack_req  (attack_req),
        .facing_left (facing_left),
        .anim_id     (anim_id),
        .frame_idx   (frame_idx),
        .flip_x      (flip_x),
        .busy        (busy),
        .anim_done   (anim_done)
    );

    typedef struct {
        int anim;
        int frame;
        int flip;
        int busy;
        int done;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   nframes[4] = '{2, 6, 4, 5};

    // Model: animation plus ticks elapsed in it.
    int m_anim = 0;
    int m_t    = 0;
    bit m_flip = 0;
    bit m_pa   = 0;
    bit m_pj   = 0;
    bit m_done = 0;
    bit cur_run  = 0;
    bit cur_face = 0;

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string nm,
                       input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d",
                     nm, act, exp);
        end
    endtask

    always @(posedge vga_clk) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("anim_id", int'(anim_id), e.anim);
            chk("frame_idx", int'(frame_idx), e.frame);
            chk("flip_x", int'(flip_x), e.flip);
            chk("busy", int'(busy), e.busy);
            chk("anim_done", int'(anim_done), e.done);
        end
    end

    task automatic model(input bit r, input bit ft,
                         input bit jr, input bit ar);
        bit busy_now;
        bit a;
        bit j;
        int nxt;
        exp_t x;
        if (r) begin
            m_anim = 0; m_t = 0; m_flip = 0;
            m_pa = 0; m_pj = 0; m_done = 0;
        end else begin
            busy_now = (m_anim >= 2);
            m_done = 0;
            a = m_pa | ar;
            j = m_pj | jr;
            if (busy_now) begin
                m_pa = 0; m_pj = 0;
            end else if (!ft) begin
                m_pa = a; m_pj = j;
            end
            if (ft && busy_now) begin
                m_t++;
                if (m_t == nframes[m_anim] * H) begin
                    m_anim = cur_run ? 1 : 0;
                    m_t = 0;
                    m_done = 1;
                end
            end else if (ft) begin
                nxt = a ? 3 : j ? 2 : cur_run ? 1 : 0;
                m_flip = cur_face;
                m_pa = 0; m_pj = 0;
                if (nxt != m_anim) begin
                    m_anim = nxt;
                    m_t = 0;
                end else begin
                    m_t++;
                end
            end
        end
        x.anim  = m_anim;
        x.frame = (m_t / H) % nframes[m_anim];
        x.flip  = int'(m_flip);
        x.busy  = (m_anim >= 2) ? 1 : 0;
        x.done  = int'(m_done);
        q.push_back(x);
    endtask

    task automatic step(input bit r, input bit ft,
                        input bit jr, input bit ar);
        @(negedge vga_clk);
        reset       = r;
        frame_tick  = ft;
        run         = cur_run;
        jump_req    = jr;
        attack_req  = ar;
        facing_left = cur_face;
        model(r, ft, jr, ar);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(0, 1, 0, 0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
        end
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; run = 1'b0;
        jump_req = 1'b0; attack_req = 1'b0;
        facing_left = 1'b0;
        step(1, 0, 0, 0);
        step(1, 1, 1, 1);
        // Idle loop, then run loop.
        cur_run = 0;
        ticks(20);
        cur_run = 1;
        ticks(30);
        // Jump between ticks while running.
        step(0, 0, 1, 0);
        ticks(20);
        // Simultaneous attack and jump, run low.
        cur_run = 0;
        step(0, 0, 1, 1);
        ticks(25);
        // Attack and facing changes during a jump.
        step(0, 1, 1, 0);
        repeat (8) begin
            cur_face = ~cur_face;
            step(0, 0, 0, 1);
            step(0, 1, 0, 0);
        end
        ticks(10);
        // Reset during attack frame 3.
        step(0, 1, 0, 1);
        ticks(12);
        step(1, 0, 0, 0);
        ticks(2);
        repeat (4000) begin
            if ($urandom_range(0, 39) == 0)
                cur_run = ~cur_run;
            if ($urandom_range(0, 24) == 0)
                cur_face = ~cur_face;
            step($urandom_range(0, 599) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 14) == 0);
        end
        step(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (q.size() != 0) @(negedge vga_clk);
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d expected 0",
                     q.size());
        end
        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end

endmodule
